pattern_stream_tx: RTL and testbench
====================================

// Module: pattern_stream_tx
// PURPOSE
//   Serial bit-stream transmitter for the 111/001 pattern-detection path.
//   Accepts parallel words over a valid/ready handshake and shifts them out LSB first,
//   one bit per clock, with a qualifying valid strobe.
//   An optional idle gap can be inserted between words. A wrapping word counter is provided.
//   Drives the serial input of the pattern detector in self-checking benches and in the datapath.
// PARAMETERS
//   WIDTH       10  bits per word, >= 2
//   GAP_CYCLES  0   idle cycles inserted after each word, 0..255
//   IDLE_BIT    0   level driven on bit_out whenever bit_valid=0
// PORTS
//   clock       in   1      single clock, rising edge
//   reset       in   1      asynchronous, active-high
//   word_in     in   WIDTH  parallel word, bit 0 transmitted first
//   word_valid  in   1      word_in valid; source holds word_in stable until accepted
//   word_ready  out  1      block can accept word_in this cycle
//   abort       in   1      synchronous: drop current word, return to IDLE
//   bit_out     out  1      serial data, registered
//   bit_valid   out  1      bit_out carries a data bit, registered
//   busy        out  1      state != IDLE
//   words_sent  out  8      count of fully transmitted words, wraps 255->0
// BEHAVIOUR
//   Reset values: state=IDLE, bit_out=IDLE_BIT, bit_valid=0, busy=0, words_sent=0.
//     word_ready=1 after reset. Reset takes effect at once, including mid-word; the partial word is lost.
//   FSM states: IDLE, SHIFT, GAP. Registers: shift reg [WIDTH-1:0], bit index, gap counter.
//   Handshake: a transfer occurs at a rising edge where word_valid & word_ready = 1.
//     word_valid with word_ready=0 is ignored. No word is buffered beyond the shift register.
//   word_ready (combinational from state, index and abort) = !abort & (IDLE | (SHIFT & last bit & GAP_CYCLES==0)).
//   IDLE: on transfer -> SHIFT. Load word. In the next cycle bit_out=word_in[0] and bit_valid=1.
//   Latency: word accepted at edge N. Bit k appears in the cycle after edge N+k, for k = 0..WIDTH-1.
//   SHIFT: each edge advances the index by 1 and drives the next bit. bit_valid stays 1.
//   At the edge leaving the last bit (index = WIDTH-1):
//     - words_sent += 1 (mod 256).
//     - If GAP_CYCLES>0 -> GAP. bit_valid=0, bit_out=IDLE_BIT.
//     - Else if a transfer occurs at the same edge -> stay in SHIFT. The new word's bit 0 follows with no bubble.
//     - Else -> IDLE. bit_valid=0, bit_out=IDLE_BIT.
//   GAP: lasts exactly GAP_CYCLES cycles with bit_valid=0, word_ready=0, bit_out=IDLE_BIT, then -> IDLE.
//   abort=1 at an edge (any state, precedence below reset only):
//     - Next state IDLE, bit_valid=0, bit_out=IDLE_BIT.
//     - words_sent is not incremented, even when abort coincides with the last bit.
//     - No word is accepted that cycle.
//   abort in IDLE: no effect apart from forcing word_ready=0 that cycle.
//   busy=1 in SHIFT and GAP, 0 in IDLE.
//   words_sent wraps 255->0 with no flag.
// TESTING
//   T1 WIDTH=10, GAP=0: send 10'b1001100111 once -> bit_out 1,1,1,0,0,1,1,0,0,1 on 10 consecutive
//      cycles with bit_valid=1. Then bit_valid=0, bit_out=0, words_sent=1.
//   T2 Back-to-back: 10'h3FF then 10'h000 with word_valid held -> 20 contiguous valid bits
//      (ten 1s, ten 0s). word_ready=1 only in IDLE and in the last-bit cycle. words_sent=2.
//   T3 GAP_CYCLES=3: two words -> exactly 3 cycles of bit_valid=0, bit_out=0 between them.
//      word_ready=0 throughout the gap.
//   T4 abort asserted during bit index 4 -> next cycle bit_valid=0, words_sent unchanged.
//      The following word starts from its bit 0.
//   T5 reset asserted between edges mid-word -> bit_valid=0, busy=0, words_sent=0 immediately,
//      before the next edge. After release, the first word transmits normally.
//   T6 Loopback of T1 stream into a golden 111/001 Mealy model (idle zeros before):
//      - 001 hits (o=01) on bits 0, 5 and 9.
//      - 111 hit (o=10) on bit 2.
//      - o=00 on all other bits.

Source files
------------

// File: rtl/pattern_stream_tx.sv
// Serial transmitter: parallel words in over valid/ready, shifted out LSB
// first with a bit_valid strobe, optional idle gap and a wrapping word count.
module pattern_stream_tx #(
  parameter int   WIDTH      = 10,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam int             IW       = $clog2(WIDTH);
  localparam logic [IW-1:0]  LAST     = IW'(WIDTH - 1);
  localparam logic [7:0]     GAP_INIT = 8'(GAP_CYCLES - 1);
  localparam bit             HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       gap_q, gap_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic [7:0]       words_q, words_d;
  logic             last_bit;
  logic             xfer;

  assign last_bit   = (state_q == S_SHIFT) && (idx_q == LAST);
  assign word_ready = !abort &&
                      ((state_q == S_IDLE) || (last_bit && !HAS_GAP));
  assign xfer       = word_valid && word_ready;

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign words_sent = words_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    bit_out_d   = IDLE_BIT;
    bit_valid_d = 1'b0;
    words_d     = words_q;

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d     = S_SHIFT;
          shift_d     = word_in >> 1;
          idx_d       = '0;
          bit_out_d   = word_in[0];
          bit_valid_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (idx_q == LAST) begin
          words_d = words_q + 8'd1;
          if (HAS_GAP) begin
            state_d = S_GAP;
            gap_d   = GAP_INIT;
          end else if (xfer) begin
            shift_d     = word_in >> 1;
            idx_d       = '0;
            bit_out_d   = word_in[0];
            bit_valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          idx_d       = idx_q + 1'b1;
          shift_d     = shift_q >> 1;
          bit_out_d   = shift_q[0];
          bit_valid_d = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // abort drops the word in flight; a coinciding last bit is not counted
    if (abort) begin
      state_d     = S_IDLE;
      bit_out_d   = IDLE_BIT;
      bit_valid_d = 1'b0;
      words_d     = words_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      bit_out_q   <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      words_q     <= words_d;
    end
  end

endmodule

// File: tb/tb_pattern_stream_tx.sv
// Bench for pattern_stream_tx: scoreboard of expected bits plus a
// word-level reference model; a second instance exercises the idle gap.
module tb_pattern_stream_tx;

  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] word_in;
  logic         word_valid;
  logic         word_ready;
  logic         abort;
  logic         bit_out;
  logic         bit_valid;
  logic         busy;
  logic [7:0]   words_sent;

  logic [W-1:0] word_in_g;
  logic         word_valid_g;
  logic         word_ready_g;
  logic         abort_g;
  logic         bit_out_g;
  logic         bit_valid_g;
  logic         busy_g;
  logic [7:0]   words_sent_g;

  always #5 clock = ~clock;

  pattern_stream_tx #(.WIDTH(W), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) dut (
    .clock(clock), .reset(reset),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .abort(abort), .bit_out(bit_out), .bit_valid(bit_valid),
    .busy(busy), .words_sent(words_sent)
  );

  pattern_stream_tx #(.WIDTH(W), .GAP_CYCLES(3), .IDLE_BIT(1'b0)) dut_g (
    .clock(clock), .reset(reset),
    .word_in(word_in_g), .word_valid(word_valid_g), .word_ready(word_ready_g),
    .abort(abort_g), .bit_out(bit_out_g), .bit_valid(bit_valid_g),
    .busy(busy_g), .words_sent(words_sent_g)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: words are queued as whole bit lists; timing is
  // tracked as "bits still to show" and "gap cycles left"
  bit q[$];
  int bits_left = 0;
  int gap_left  = 0;
  int words_m   = 0;

  function automatic bit exp_ready();
    return !abort && ((bits_left == 0 && gap_left == 0) || bits_left == 1);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bits_left = 0;
      gap_left  = 0;
      words_m   = 0;
      q.delete();
    end else begin
      bit xf;
      bit load;
      xf   = word_valid && exp_ready();
      load = 0;
      if (abort) begin
        bits_left = 0;
        gap_left  = 0;
        q.delete();
      end else if (bits_left > 0) begin
        bits_left--;
        if (bits_left == 0) begin
          words_m = (words_m + 1) % 256;
          load    = xf;
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end else begin
        load = xf;
      end
      if (load) begin
        bits_left = W;
        for (int i = 0; i < W; i++) q.push_back(word_in[i]);
      end
    end
  end

  // monitor
  bit       t6_on = 0;
  logic [2:0] hist;
  logic [1:0] t6_o[$];
  int       run_len = 0;
  int       max_run = 0;

  always @(negedge clock) begin
    if (!reset) begin
      check("ready", word_ready, exp_ready());
      check("valid", bit_valid, bits_left > 0);
      check("busy", busy, (bits_left > 0) || (gap_left > 0));
      check("words_sent", words_sent, words_m);
      if (bit_valid) begin
        if (q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          bit e;
          e = q.pop_front();
          check("bit_out", bit_out, e);
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (t6_on) begin
          hist = {hist[1:0], bit_out};
          t6_o.push_back({hist == 3'b111, hist == 3'b001});
        end
      end else begin
        check("idle_bit", bit_out, 0);
        run_len = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    bit acc;
    int n;
    word_in    = w;
    word_valid = 1;
    acc = 0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = word_ready;
      step();
      n++;
    end
    word_valid = 0;
    check("send_accept", acc, 1);
  endtask

  logic [1:0] t6_exp[W] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00,
                            2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
  logic [W-1:0] wg[2] = '{10'h2A5, 10'h1C3};

  initial begin
    logic [7:0] ws;
    reset        = 1;
    word_in      = '0;
    word_valid   = 0;
    abort        = 0;
    word_in_g    = '0;
    word_valid_g = 0;
    abort_g      = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", bit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_words", words_sent, 0);
    check("rst_ready", word_ready, 1);
    check("rst_bit", bit_out, 0);
    reset = 0;
    step();

    // T1 + T6: single word and golden 111/001 detector on its stream
    hist  = 3'b000;
    t6_on = 1;
    max_run = 0;
    send_word(10'b1001100111);
    repeat (12) step();
    t6_on = 0;
    check("t1_words", words_sent, 1);
    check("t1_run", max_run, W);
    check("t6_len", t6_o.size(), W);
    for (int i = 0; i < W && i < t6_o.size(); i++)
      check($sformatf("t6_o%0d", i), t6_o[i], t6_exp[i]);

    // T2: back-to-back
    max_run = 0;
    ws = words_sent;
    send_word(10'h3FF);
    send_word(10'h000);
    repeat (12) step();
    check("t2_run", max_run, 2 * W);
    check("t2_words", words_sent, 8'(ws + 8'd2));

    // T4: abort while bit 4 is on the line
    ws = words_sent;
    send_word(10'h155);
    repeat (4) step();
    abort = 1;
    step();
    abort = 0;
    check("t4_valid", bit_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_words", words_sent, ws);
    send_word(10'h0F3);
    repeat (12) step();
    check("t4_words2", words_sent, 8'(ws + 8'd1));

    // T5: asynchronous reset between edges
    send_word(10'h2C9);
    repeat (3) step();
    @(negedge clock);
    #2;
    reset = 1;
    #1;
    check("t5_valid", bit_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_words", words_sent, 0);
    step();
    reset = 0;
    step();
    send_word(10'h18E);
    repeat (12) step();
    check("t5_words2", words_sent, 1);

    // randomized traffic with sporadic aborts
    for (int c = 0; c < 600; c++) begin
      bit acc;
      @(negedge clock);
      acc = word_valid && word_ready;
      step();
      if (!word_valid || acc) begin
        word_valid = ($urandom % 3) != 0;
        word_in    = W'($urandom);
      end
      abort = ($urandom % 20) == 0;
    end
    word_valid = 0;
    abort      = 0;
    repeat (12) step();

    // counter wrap over 257 back-to-back words
    ws = words_sent;
    for (int n = 0; n < 257; n++) send_word(W'($urandom));
    repeat (12) step();
    check("wrap_words", words_sent, 8'(ws + 8'd1));
    check("queue_drained", q.size(), 0);

    // T3: gap instance, two words with valid held
    begin
      bit got[$];
      int wi    = 0;
      int gapc  = 0;
      int bad   = 0;
      word_in_g    = wg[0];
      word_valid_g = 1;
      for (int c = 0; c < 60; c++) begin
        bit acc;
        @(negedge clock);
        if (bit_valid_g) got.push_back(bit_out_g);
        else if (busy_g) begin
          if (got.size() == W) gapc++;
          if (word_ready_g || bit_out_g) bad++;
        end
        acc = word_valid_g && word_ready_g;
        step();
        if (acc) begin
          wi++;
          if (wi < 2) word_in_g = wg[wi];
          else        word_valid_g = 0;
        end
      end
      check("t3_accepted", wi, 2);
      check("t3_gap_cycles", gapc, 3);
      check("t3_gap_bad", bad, 0);
      check("t3_bits", got.size(), 2 * W);
      for (int i = 0; i < 2 * W && i < got.size(); i++)
        check($sformatf("t3_bit%0d", i), got[i], wg[i / W][i % W]);
      check("t3_words", words_sent_g, 2);
      check("t3_idle", busy_g, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
